// File: rtl/ser_tx_queue_pkg.sv
// ser_tx_queue_pkg: shared definitions for the buffered 8N1 serial transmitter.
//   - Default bit-cell length and queue depth.
//   - Transmit FSM state encoding: IDLE=0, START=1, DATA=2, STOP=3.
package ser_tx_queue_pkg;

    // 2 x 53-clock half-period bit cell on the hx8kdemo serial link
    localparam int unsigned DefClkDiv    = 106;
    localparam int unsigned DefFifoDepth = 16;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StData  = 2'd2,
        StStop  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/ser_tx_fifo.sv
// ser_tx_fifo: synchronous byte FIFO with first-word-fall-through read.
// Ports:
//   clk, reset    posedge clock, synchronous active-high reset (flushes the queue)
//   wr_valid_i    write request; accepted when wr_ready_o is high
//   wr_data_i     byte to write
//   wr_ready_o    not full, decoded from the registered level
//   rd_en_i       pop the head entry (ignored when empty)
//   rd_data_o     current head entry, valid whenever empty_o is low
//   empty_o       no entries stored
//   level_o       registered entry count
module ser_tx_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned LVL_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_valid_i,
    input  logic [7:0]       wr_data_i,
    output logic             wr_ready_o,
    input  logic             rd_en_i,
    output logic [7:0]       rd_data_o,
    output logic             empty_o,
    output logic [LVL_W-1:0] level_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [7:0]       mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic             full, push, pop;

    // Pointers carry one extra wrap bit: same index with differing MSBs means full.
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);

    // A push at full is dropped even if a pop happens in the same cycle.
    assign push = wr_valid_i && !full;
    assign pop  = rd_en_i && !empty_o;

    assign wr_ready_o = (level_q != LVL_W'(DEPTH));
    assign rd_data_o  = mem_q[rd_ptr_q[AW-1:0]];
    assign level_o    = level_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/ser_tx_queue.sv
// ser_tx_queue: buffered 8N1 UART transmitter, LSB first, line idles high.
// Ports:
//   clk, reset    posedge clock, synchronous active-high reset (abandons any frame)
//   in_data       byte to queue, sampled only when accepted
//   in_valid      in_data valid this cycle
//   in_ready      queue not full; accept on in_valid && in_ready
//   ser_tx        registered serial line
//   busy          frame on the line or bytes queued (registered, aligned with ser_tx)
//   fifo_level    queued bytes, excluding the byte being shifted
module ser_tx_queue
    import ser_tx_queue_pkg::*;
#(
    parameter int unsigned CLK_DIV    = DefClkDiv,
    parameter int unsigned FIFO_DEPTH = DefFifoDepth,
    parameter int unsigned LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_tx,
    output logic             busy,
    output logic [LVL_W-1:0] fifo_level
);

    localparam int unsigned DivW = $clog2(CLK_DIV);
    localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

    tx_state_e       state_q, state_d;
    logic [DivW-1:0] div_cnt_q, div_cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            ser_tx_q, ser_tx_d;
    logic            busy_q, busy_d;
    logic            pop, fifo_empty, cell_end;
    logic [7:0]      fifo_rd_data;

    ser_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .wr_valid_i (in_valid),
        .wr_data_i  (in_data),
        .wr_ready_o (in_ready),
        .rd_en_i    (pop),
        .rd_data_o  (fifo_rd_data),
        .empty_o    (fifo_empty),
        .level_o    (fifo_level)
    );

    assign cell_end = (div_cnt_q == DivLast);

    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        pop       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    shift_d   = fifo_rd_data;
                    div_cnt_d = '0;
                    bit_idx_d = '0;
                    state_d   = StStart;
                end
            end
            StStart: begin
                if (cell_end) begin
                    div_cnt_d = '0;
                    bit_idx_d = '0;
                    state_d   = StData;
                end else begin
                    div_cnt_d = div_cnt_q + DivW'(1);
                end
            end
            StData: begin
                if (cell_end) begin
                    div_cnt_d = '0;
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = StStop;
                end else begin
                    div_cnt_d = div_cnt_q + DivW'(1);
                end
            end
            StStop: begin
                if (cell_end) begin
                    div_cnt_d = '0;
                    // Chain straight into the next start bit when more bytes wait.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_rd_data;
                        state_d = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DivW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Line and busy are registered from the current state, so both trail the FSM by one clock.
    always_comb begin
        ser_tx_d = 1'b1;
        unique case (state_q)
            StStart: ser_tx_d = 1'b0;
            StData:  ser_tx_d = shift_q[0];
            default: ser_tx_d = 1'b1;
        endcase
        busy_d = (state_q != StIdle) || (fifo_level != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            div_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            ser_tx_q  <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            ser_tx_q  <= ser_tx_d;
            busy_q    <= busy_d;
        end
    end

    assign ser_tx = ser_tx_q;
    assign busy   = busy_q;

endmodule
